// File: rtl/lsu_dcache_adapter.sv
// LSU-to-L1D adapter: aligns RV64 ld/st into doubleword requests, tracks them in order, extends load data.
// Request 1 cycle after accept, writeback 1 cycle after response; op_ready drops on full FIFO, stalled request, or non-RUN state.

module sync_fifo #(
  parameter int W  = 8,
  parameter int DP = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_vld,
  input  logic [W-1:0] push_dat,
  input  logic         pop_vld,
  output logic [W-1:0] head_dat,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DP);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic [W-1:0]  mem_q [DP];
  logic [W-1:0]  mem_d [DP];
  logic          do_push, do_pop;

  assign full     = (cnt_q == (AW+1)'(DP));
  assign empty    = (cnt_q == '0);
  assign head_dat = mem_q[rd_ptr_q];

  always_comb begin
    do_pop   = pop_vld & ~empty;
    // A pop frees the head slot in the same cycle, so a full FIFO can still take a push.
    do_push  = push_vld & (~full | do_pop);
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    cnt_d    = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    mem_d    = mem_q;
    if (do_push) mem_d[wr_ptr_q] = push_dat;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end
endmodule

module lsu_dcache_adapter #(
  parameter int OT_DP = 4,
  parameter int RD_W  = 6
) (
  input  logic            CLK,
  input  logic            RSTn,
  input  logic            op_valid,
  output logic            op_ready,
  input  logic [31:0]     op_addr,
  input  logic [63:0]     op_wdata,
  input  logic [3:0]      op_fun,
  input  logic [RD_W-1:0] op_rd,
  input  logic            op_fence,
  output logic            dc_req_valid,
  input  logic            dc_req_ready,
  output logic [31:0]     dc_addr,
  output logic [63:0]     dc_wdata,
  output logic [7:0]      dc_wstrb,
  output logic            dc_wen,
  input  logic            dc_rsp_valid,
  output logic            dc_rsp_ready,
  input  logic [63:0]     dc_rdata,
  output logic            dl1_fence,
  output logic            wb_valid,
  output logic [RD_W-1:0] wb_rd,
  output logic [63:0]     wb_data,
  output logic            wb_is_load,
  output logic            exc_valid,
  output logic [31:0]     exc_addr,
  output logic            busy
);
  typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_FPULSE, ST_EXC} state_t;

  typedef struct packed {
    logic [RD_W-1:0] rd;
    logic [3:0]      fun;
    logic [2:0]      off;
  } ot_t;

  localparam int OT_W = $bits(ot_t);

  state_t          state_q, state_d;
  logic            req_vld_q, req_vld_d, dc_wen_q, dc_wen_d;
  logic [31:0]     dc_addr_q, dc_addr_d, exc_addr_q, exc_addr_d;
  logic [63:0]     dc_wdata_q, dc_wdata_d, wb_data_q, wb_data_d;
  logic [7:0]      dc_wstrb_q, dc_wstrb_d;
  logic            wb_valid_q, wb_valid_d, wb_is_load_q, wb_is_load_d;
  logic [RD_W-1:0] wb_rd_q, wb_rd_d;

  ot_t             push_ent, head_ent;
  logic [OT_W-1:0] head_raw;
  logic            fifo_full, fifo_empty, pop;
  logic [1:0]      size;
  logic [2:0]      low_mask;
  logic [8:0]      strb_base;
  logic            illegal, misal, bad, base_rdy, accept, acc_mem, acc_exc, acc_fence;
  logic            sx;
  logic [63:0]     sh, ext;

  always_comb begin
    size      = op_fun[1:0];
    low_mask  = {size[1] & size[0], size[1], size[1] | size[0]};
    misal     = |(op_addr[2:0] & low_mask);
    illegal   = (op_fun == 4'd7) | (op_fun[3:2] == 2'b11);
    bad       = ~op_fence & (illegal | misal);
    base_rdy  = (state_q == ST_RUN) & ~fifo_full & (~req_vld_q | dc_req_ready);
    // Faulting ops wait for a quiet pipe so the exception is precise.
    op_ready  = RSTn & base_rdy & (~bad | (fifo_empty & ~req_vld_q));
    accept    = op_valid & op_ready;
    acc_fence = accept & op_fence;
    acc_exc   = accept & bad;
    acc_mem   = accept & ~op_fence & ~bad;
    strb_base = (9'd1 << (4'd1 << size)) - 9'd1;
    push_ent  = '{rd: op_rd, fun: op_fun, off: op_addr[2:0]};
  end

  always_comb begin
    req_vld_d  = req_vld_q & ~dc_req_ready;
    dc_addr_d  = dc_addr_q;
    dc_wdata_d = dc_wdata_q;
    dc_wstrb_d = dc_wstrb_q;
    dc_wen_d   = dc_wen_q;
    if (acc_mem) begin
      req_vld_d  = 1'b1;
      dc_addr_d  = {op_addr[31:3], 3'b000};
      dc_wdata_d = op_wdata << {op_addr[2:0], 3'b000};
      dc_wstrb_d = strb_base[7:0] << op_addr[2:0];
      dc_wen_d   = op_fun[3];
    end
    exc_addr_d = acc_exc ? op_addr : exc_addr_q;

    state_d = state_q;
    case (state_q)
      ST_RUN: begin
        if (acc_fence)    state_d = ST_DRAIN;
        else if (acc_exc) state_d = ST_EXC;
      end
      ST_DRAIN:  if (fifo_empty & ~req_vld_q) state_d = ST_FPULSE;
      ST_FPULSE: state_d = ST_RUN;
      default:   state_d = ST_RUN;
    endcase
  end

  always_comb begin
    pop      = dc_rsp_valid & ~fifo_empty;
    head_ent = ot_t'(head_raw);
    sx       = ~head_ent.fun[2];
    sh       = dc_rdata >> {head_ent.off, 3'b000};
    case (head_ent.fun[1:0])
      2'd0:    ext = {{56{sx & sh[7]}}, sh[7:0]};
      2'd1:    ext = {{48{sx & sh[15]}}, sh[15:0]};
      2'd2:    ext = {{32{sx & sh[31]}}, sh[31:0]};
      default: ext = sh;
    endcase
    wb_valid_d   = pop;
    wb_rd_d      = wb_rd_q;
    wb_data_d    = wb_data_q;
    wb_is_load_d = wb_is_load_q;
    if (pop) begin
      wb_rd_d      = head_ent.rd;
      wb_is_load_d = ~head_ent.fun[3];
      wb_data_d    = head_ent.fun[3] ? 64'd0 : ext;
    end
  end

  sync_fifo #(.W(OT_W), .DP(OT_DP)) u_ot_fifo (
    .clk      (CLK),
    .rst_n    (RSTn),
    .push_vld (acc_mem),
    .push_dat (push_ent),
    .pop_vld  (pop),
    .head_dat (head_raw),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q      <= ST_RUN;
      req_vld_q    <= 1'b0;
      dc_addr_q    <= '0;
      dc_wdata_q   <= '0;
      dc_wstrb_q   <= '0;
      dc_wen_q     <= 1'b0;
      exc_addr_q   <= '0;
      wb_valid_q   <= 1'b0;
      wb_rd_q      <= '0;
      wb_data_q    <= '0;
      wb_is_load_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      req_vld_q    <= req_vld_d;
      dc_addr_q    <= dc_addr_d;
      dc_wdata_q   <= dc_wdata_d;
      dc_wstrb_q   <= dc_wstrb_d;
      dc_wen_q     <= dc_wen_d;
      exc_addr_q   <= exc_addr_d;
      wb_valid_q   <= wb_valid_d;
      wb_rd_q      <= wb_rd_d;
      wb_data_q    <= wb_data_d;
      wb_is_load_q <= wb_is_load_d;
    end
  end

  assign dc_req_valid = req_vld_q;
  assign dc_addr      = dc_addr_q;
  assign dc_wdata     = dc_wdata_q;
  assign dc_wstrb     = dc_wstrb_q;
  assign dc_wen       = dc_wen_q;
  assign dc_rsp_ready = ~fifo_empty;
  assign dl1_fence    = (state_q == ST_FPULSE);
  assign exc_valid    = (state_q == ST_EXC);
  assign exc_addr     = exc_addr_q;
  assign wb_valid     = wb_valid_q;
  assign wb_rd        = wb_rd_q;
  assign wb_data      = wb_data_q;
  assign wb_is_load   = wb_is_load_q;
  assign busy         = (state_q != ST_RUN) | ~fifo_empty | req_vld_q;
endmodule

// File: tb/tb_lsu_dcache_adapter.sv
// Directed bench for lsu_dcache_adapter: hand-computed vectors for alignment, extension, ordering, exceptions and fences.

module tb_lsu_dcache_adapter;
  logic        CLK, RSTn;
  logic        op_valid, op_ready, op_fence;
  logic [31:0] op_addr;
  logic [63:0] op_wdata;
  logic [3:0]  op_fun;
  logic [5:0]  op_rd;
  logic        dc_req_valid, dc_req_ready, dc_wen;
  logic [31:0] dc_addr;
  logic [63:0] dc_wdata;
  logic [7:0]  dc_wstrb;
  logic        dc_rsp_valid, dc_rsp_ready;
  logic [63:0] dc_rdata;
  logic        dl1_fence, wb_valid, wb_is_load, exc_valid, busy;
  logic [5:0]  wb_rd;
  logic [63:0] wb_data;
  logic [31:0] exc_addr;

  int n_vec = 0;
  int n_err = 0;

  lsu_dcache_adapter #(.OT_DP(4), .RD_W(6)) dut (
    .CLK(CLK), .RSTn(RSTn),
    .op_valid(op_valid), .op_ready(op_ready), .op_addr(op_addr), .op_wdata(op_wdata),
    .op_fun(op_fun), .op_rd(op_rd), .op_fence(op_fence),
    .dc_req_valid(dc_req_valid), .dc_req_ready(dc_req_ready), .dc_addr(dc_addr),
    .dc_wdata(dc_wdata), .dc_wstrb(dc_wstrb), .dc_wen(dc_wen),
    .dc_rsp_valid(dc_rsp_valid), .dc_rsp_ready(dc_rsp_ready), .dc_rdata(dc_rdata),
    .dl1_fence(dl1_fence), .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .wb_is_load(wb_is_load), .exc_valid(exc_valid), .exc_addr(exc_addr), .busy(busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic issue(input logic [3:0] f, input logic [31:0] a, input logic [63:0] wd,
                       input logic [5:0] rd);
    int n;
    n = 0;
    op_valid = 1'b1; op_fence = 1'b0; op_fun = f; op_addr = a; op_wdata = wd; op_rd = rd;
    #1;
    while (!op_ready && n < 20) begin
      tick();
      n++;
    end
    if (n == 20) chk("issue_timeout", 64'd0, 64'd1);
    tick();
    op_valid = 1'b0;
  endtask

  task automatic fence();
    op_valid = 1'b1; op_fence = 1'b1;
    #1;
    chk("fence_rdy", op_ready, 1);
    tick();
    op_valid = 1'b0; op_fence = 1'b0;
  endtask

  task automatic rsp(input logic [63:0] d);
    dc_rsp_valid = 1'b1; dc_rdata = d;
    tick();
    dc_rsp_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    op_valid = 0; op_fence = 0; op_addr = 0; op_wdata = 0; op_fun = 0; op_rd = 0;
    dc_req_ready = 1; dc_rsp_valid = 0; dc_rdata = 0;
    RSTn = 1'b1;
    #1 RSTn = 1'b0;
    #10;
    chk("rst_op_ready", op_ready, 0);
    chk("rst_req_vld", dc_req_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_wb_vld", wb_valid, 0);
    chk("rst_fence", dl1_fence, 0);
    chk("rst_exc", exc_valid, 0);
    @(negedge CLK) RSTn = 1'b1;
    tick();
    chk("run_op_ready", op_ready, 1);

    // LW at upper word, negative value
    issue(4'd2, 32'h8000_0004, 64'd0, 6'd5);
    chk("lw_req_vld", dc_req_valid, 1);
    chk("lw_addr", dc_addr, 64'h8000_0000);
    chk("lw_strb", dc_wstrb, 8'hF0);
    chk("lw_wen", dc_wen, 0);
    chk("lw_rsp_rdy", dc_rsp_ready, 1);
    rsp(64'h8765_4321_0000_0000);
    chk("lw_wb_vld", wb_valid, 1);
    chk("lw_wb_rd", wb_rd, 5);
    chk("lw_wb_data", wb_data, 64'hFFFF_FFFF_8765_4321);
    chk("lw_wb_ld", wb_is_load, 1);

    // SH to top halfword
    issue(4'd9, 32'h0000_1006, 64'hBEEF, 6'd7);
    chk("sh_wdata", dc_wdata, 64'hBEEF_0000_0000_0000);
    chk("sh_strb", dc_wstrb, 8'hC0);
    chk("sh_wen", dc_wen, 1);
    rsp(64'h1234_5678_9ABC_DEF0);
    chk("sh_wb_vld", wb_valid, 1);
    chk("sh_wb_data", wb_data, 0);
    chk("sh_wb_ld", wb_is_load, 0);
    chk("sh_wb_rd", wb_rd, 7);

    // LBU / LB on byte 3 = 0x80
    issue(4'd4, 32'h3, 64'd0, 6'd1);
    chk("lbu_strb", dc_wstrb, 8'h08);
    rsp(64'h0000_0000_8000_0000);
    chk("lbu_data", wb_data, 64'h80);
    issue(4'd0, 32'h3, 64'd0, 6'd2);
    rsp(64'h0000_0000_8000_0000);
    chk("lb_data", wb_data, 64'hFFFF_FFFF_FFFF_FF80);

    // SD held while cache stalls
    dc_req_ready = 0;
    issue(4'd11, 32'h40, 64'h1122_3344_5566_7788, 6'd9);
    chk("sd_strb", dc_wstrb, 8'hFF);
    chk("sd_stall_rdy", op_ready, 0);
    tick();
    chk("sd_hold_vld", dc_req_valid, 1);
    chk("sd_hold_wdata", dc_wdata, 64'h1122_3344_5566_7788);
    dc_req_ready = 1;
    tick();
    chk("sd_req_done", dc_req_valid, 0);
    rsp(64'd0);
    chk("sd_wb_rd", wb_rd, 9);

    // Fill the 4-deep FIFO, then free one slot
    op_valid = 1; op_fun = 4'd3; op_fence = 0;
    for (int i = 0; i < 4; i++) begin
      op_addr = 32'h100 + 32'(8 * i); op_rd = 6'(10 + i);
      #1;
      chk("fill_rdy", op_ready, 1);
      tick();
    end
    op_addr = 32'h120; op_rd = 6'd14;
    #1;
    chk("full_rdy", op_ready, 0);
    dc_rsp_valid = 1; dc_rdata = 64'hA0;
    tick();
    dc_rsp_valid = 0;
    chk("pop_rdy", op_ready, 1);
    chk("ord_rd0", wb_rd, 10);
    chk("ord_data0", wb_data, 64'hA0);
    tick();
    op_valid = 0;
    for (int i = 1; i < 5; i++) begin
      rsp(64'hA0 + 64'(i));
      chk("ord_vld", wb_valid, 1);
      chk("ord_rd", wb_rd, 6'(10 + i));
      chk("ord_data", wb_data, 64'hA0 + 64'(i));
    end
    chk("drained_rsp_rdy", dc_rsp_ready, 0);

    // Misaligned LD on empty pipe
    op_valid = 1; op_fun = 4'd3; op_addr = 32'h1004; op_rd = 6'd2;
    #1;
    chk("mis_rdy", op_ready, 1);
    tick();
    op_valid = 0;
    chk("mis_no_req", dc_req_valid, 0);
    chk("mis_exc", exc_valid, 1);
    chk("mis_exc_addr", exc_addr, 32'h1004);
    chk("mis_fifo", dc_rsp_ready, 0);
    tick();
    chk("mis_exc_pulse", exc_valid, 0);
    chk("mis_run_rdy", op_ready, 1);

    // Misaligned LH blocked behind an outstanding LW
    issue(4'd2, 32'h0, 64'd0, 6'd3);
    op_valid = 1; op_fun = 4'd1; op_addr = 32'h5;
    #1;
    chk("mis_block", op_ready, 0);
    rsp(64'h0000_0000_7FFF_FFFF);
    chk("lw_pos_data", wb_data, 64'h7FFF_FFFF);
    op_valid = 1;
    #1;
    chk("mis_unblock", op_ready, 1);
    tick();
    op_valid = 0;
    chk("mis2_exc", exc_valid, 1);
    chk("mis2_addr", exc_addr, 32'h5);
    tick();

    // Illegal function code
    op_valid = 1; op_fun = 4'd7; op_addr = 32'h8;
    #1;
    tick();
    op_valid = 0;
    chk("ill_exc", exc_valid, 1);
    chk("ill_no_req", dc_req_valid, 0);
    tick();

    // Fence with two outstanding loads
    issue(4'd2, 32'h10, 64'd0, 6'd20);
    issue(4'd2, 32'h18, 64'd0, 6'd21);
    fence();
    chk("drn_fence0", dl1_fence, 0);
    chk("drn_rdy", op_ready, 0);
    chk("drn_busy", busy, 1);
    rsp(64'h1);
    chk("drn_fence1", dl1_fence, 0);
    chk("drn_rd20", wb_rd, 20);
    rsp(64'h2);
    chk("drn_fence2", dl1_fence, 0);
    chk("drn_rd21", wb_rd, 21);
    tick();
    chk("fp_fence", dl1_fence, 1);
    chk("fp_rdy", op_ready, 0);
    tick();
    chk("fp_pulse_end", dl1_fence, 0);
    chk("fp_run_rdy", op_ready, 1);
    chk("fp_busy", busy, 0);

    // Async reset while draining
    issue(4'd3, 32'h20, 64'd0, 6'd30);
    fence();
    chk("pre_rst_rsp_rdy", dc_rsp_ready, 1);
    #2 RSTn = 1'b0;
    #1;
    chk("arst_rsp_rdy", dc_rsp_ready, 0);
    chk("arst_busy", busy, 0);
    chk("arst_wb_rd", wb_rd, 0);
    chk("arst_rdy", op_ready, 0);
    chk("arst_fence", dl1_fence, 0);
    @(negedge CLK) RSTn = 1'b1;
    tick();
    chk("post_rst_rdy", op_ready, 1);

    // Response with nothing outstanding is dropped
    rsp(64'hDEAD);
    chk("stray_rsp", wb_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
